// File: rtl/motor_pwm_pkg.sv
// motor_pwm_pkg: register map, status bit positions and per-channel state type
// shared by the motor_pwm_bank top level and its channel slices.
package motor_pwm_pkg;

  localparam logic [4:0] ADDR_PERIOD = 5'd0;
  localparam logic [4:0] ADDR_ENABLE = 5'd1;
  localparam logic [4:0] ADDR_STATUS = 5'd2;
  localparam logic [4:0] ADDR_DUTY0  = 5'd4;

  localparam int STATUS_RUNNING_BIT = 0;
  localparam int STATUS_RAMPING_BIT = 1;
  localparam int STATUS_BRAKE_LSB   = 8;
  localparam int DUTY_DIR_BIT       = 31;

  typedef enum logic {
    RUN   = 1'b0,
    BRAKE = 1'b1
  } chan_state_t;

endpackage

// File: rtl/motor_pwm_chan.sv
// motor_pwm_chan: one motor channel. Holds the shadow (bus-written) and active
// (period-aligned) duty/direction, the RUN/BRAKE reversal sequence and the
// registered PWM compare against the shared counter.
// Optional build macro MOTOR_PWM_RAMP_EN: active duty slews toward the shadow
// value by at most RAMP_STEP per period, and a reversal ramps down to 0 first.
import motor_pwm_pkg::*;

module motor_pwm_chan #(
  parameter int WIDTH     = 14,
  parameter int RAMP_STEP = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic             wr_dir,
  input  logic             wrap,
  input  logic             running,
  input  logic             enable,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm,
  output logic             dir,
  output logic             ramping,
  output logic [WIDTH-1:0] shadow_duty,
  output logic             shadow_dir,
  output chan_state_t      state
);

`ifdef MOTOR_PWM_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  // Without ramping the step is larger than any possible difference, so the
  // same slew function degenerates into a direct load.
  localparam int STEP_EFF = RAMP_EN ? RAMP_STEP : (1 << WIDTH);

  logic [WIDTH-1:0] duty_act;
  logic             dir_mismatch;

  function automatic logic [WIDTH-1:0] ramp_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    int diff;
    diff = int'(tgt) - int'(cur);
    if (diff < 0) diff = -diff;
    if (diff <= STEP_EFF) return tgt;
    else if (tgt > cur) return cur + WIDTH'(STEP_EFF);
    else return cur - WIDTH'(STEP_EFF);
  endfunction

  assign dir_mismatch = (shadow_dir != dir);
  assign ramping      = RAMP_EN & ((duty_act != shadow_duty) | dir_mismatch | (state == BRAKE));

  // Shadow capture, wrap-time loading with the RUN/BRAKE reversal sequence,
  // and the registered compare output.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_duty <= '0;
      shadow_dir  <= 1'b0;
      duty_act    <= '0;
      dir         <= 1'b0;
      state       <= RUN;
      pwm         <= 1'b0;
    end else begin
      if (wr_en) begin
        shadow_duty <= wr_duty;
        shadow_dir  <= wr_dir;
      end
      if (wrap) begin
        case (state)
          RUN: begin
            if (dir_mismatch) begin
              // With ramping the duty must reach 0 before the brake period.
              if (RAMP_EN && (duty_act != '0)) duty_act <= ramp_toward(duty_act, '0);
              else state <= BRAKE;
            end else begin
              duty_act <= ramp_toward(duty_act, shadow_duty);
            end
          end
          BRAKE: begin
            state    <= RUN;
            dir      <= shadow_dir;
            duty_act <= ramp_toward(duty_act, shadow_duty);
          end
          default: state <= RUN;
        endcase
      end
      pwm <= running & enable & (state != BRAKE) & (cnt < duty_act);
    end
  end

endmodule

// File: rtl/motor_pwm_bank.sv
// motor_pwm_bank: multi-channel PWM motor driver with an Avalon-MM slave.
// Shared prescaler and period counter feed CHANNELS motor_pwm_chan slices.
// Optional build macro MOTOR_PWM_RAMP_EN enables per-period duty ramping
// (handled inside motor_pwm_chan; reported in STATUS bit1).
//
// Bus handshake: a write is accepted in the cycle avs_write is high; a read
// issued with avs_read returns avs_readdata on the following cycle and the
// bus is never stalled (no waitrequest). avs_readdata is 0 when not reading.
import motor_pwm_pkg::*;

module motor_pwm_bank #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 14,
  parameter int PRESC     = 1,
  parameter int RAMP_STEP = 64
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [4:0]          avs_address,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  input  logic                avs_read,
  output logic [31:0]         avs_readdata,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] dir_out,
  output logic                period_tick
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [WIDTH-1:0]    period;
  logic [CHANNELS-1:0] enable;
  logic [WIDTH-1:0]    cnt;
  logic [PW-1:0]       presc_cnt;
  logic                running;
  logic                tick;
  logic                wrap;
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  logic [CHANNELS-1:0] wr_sel;
  logic [CHANNELS-1:0] brake_w;
  logic [CHANNELS-1:0] ramping_w;
  logic [CHANNELS-1:0] shadow_dir_w;
  logic [WIDTH-1:0]    shadow_duty_w [CHANNELS];
  chan_state_t         chan_state    [CHANNELS];

  assign running      = (period != '0);
  assign tick         = running && (presc_cnt == PW'(PRESC - 1));
  assign wrap         = tick && (cnt >= period - WIDTH'(1));
  assign unused_wdata = ^avs_writedata;

  // Configuration registers written directly from the bus.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      period <= '0;
      enable <= '0;
    end else if (avs_write) begin
      if (avs_address == ADDR_PERIOD) period <= avs_writedata[WIDTH-1:0];
      if (avs_address == ADDR_ENABLE) enable <= avs_writedata[CHANNELS-1:0];
    end
  end

  // Prescaler and period counter; both held at 0 while PERIOD is 0.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      presc_cnt   <= '0;
      cnt         <= '0;
      period_tick <= 1'b0;
    end else begin
      if (!running || tick) presc_cnt <= '0;
      else presc_cnt <= presc_cnt + PW'(1);
      if (!running) cnt <= '0;
      else if (tick) cnt <= wrap ? '0 : cnt + WIDTH'(1);
      period_tick <= wrap;
    end
  end

  // Read decode; DUTY_i reads back the shadow (last written) value.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_PERIOD: rd_mux[WIDTH-1:0] = period;
      ADDR_ENABLE: rd_mux[CHANNELS-1:0] = enable;
      ADDR_STATUS: begin
        rd_mux[STATUS_RUNNING_BIT]               = running;
        rd_mux[STATUS_RAMPING_BIT]               = |ramping_w;
        rd_mux[STATUS_BRAKE_LSB +: CHANNELS]     = brake_w;
      end
      default: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (avs_address == ADDR_DUTY0 + 5'(i)) begin
            rd_mux[WIDTH-1:0]    = shadow_duty_w[i];
            rd_mux[DUTY_DIR_BIT] = shadow_dir_w[i];
          end
        end
      end
    endcase
  end

  // One-cycle read data register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) avs_readdata <= '0;
    else avs_readdata <= avs_read ? rd_mux : '0;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign wr_sel[i]  = avs_write && (avs_address == ADDR_DUTY0 + 5'(i));
    assign brake_w[i] = (chan_state[i] == BRAKE);

    motor_pwm_chan #(
      .WIDTH     (WIDTH),
      .RAMP_STEP (RAMP_STEP)
    ) u_chan (
      .clk         (clk_clk),
      .reset       (reset_reset),
      .wr_en       (wr_sel[i]),
      .wr_duty     (avs_writedata[WIDTH-1:0]),
      .wr_dir      (avs_writedata[DUTY_DIR_BIT]),
      .wrap        (wrap),
      .running     (running),
      .enable      (enable[i]),
      .cnt         (cnt),
      .pwm         (pwm_out[i]),
      .dir         (dir_out[i]),
      .ramping     (ramping_w[i]),
      .shadow_duty (shadow_duty_w[i]),
      .shadow_dir  (shadow_dir_w[i]),
      .state       (chan_state[i])
    );
  end

endmodule

// File: tb/tb_motor_pwm_bank.sv
// tb_motor_pwm_bank: self-checking bench for motor_pwm_bank (default build).
// Expected behaviour is stated per period: high cycles = min(duty, PERIOD)
// when enabled, a reversal costs one dark period, ticks every PERIOD cycles.
module tb_motor_pwm_bank;

  localparam int CH = 4;
  localparam int W  = 14;

  logic          clk_clk = 1'b0;
  logic          reset_reset;
  logic [4:0]    avs_address;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic          avs_read;
  logic [31:0]   avs_readdata;
  logic [CH-1:0] pwm_out;
  logic [CH-1:0] dir_out;
  logic          period_tick;

  int errors = 0;
  int checks = 0;
  int hi_cnt [CH];
  int win_len;
  logic [CH-1:0] model_dir = '0;

  motor_pwm_bank #(.CHANNELS(CH), .WIDTH(W), .PRESC(1), .RAMP_STEP(64)) dut (
    .clk_clk       (clk_clk),
    .reset_reset   (reset_reset),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .pwm_out       (pwm_out),
    .dir_out       (dir_out),
    .period_tick   (period_tick)
  );

  // clock / reset
  always #5 clk_clk = ~clk_clk;

  // driver tasks: all start and end on a falling edge
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk_clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (period_tick !== 1'b1 && n < 1000) begin
      @(negedge clk_clk);
      n++;
    end
    checks++;
    if (period_tick !== 1'b1) begin
      errors++;
      $display("FAIL wait_tick: period_tick=%b after %0d cycles, expected 1", period_tick, n);
    end
  endtask

  // Counts high cycles per channel until the next tick; optionally issues one
  // write when the window has reached wr_at cycles.
  task automatic measure(input int wr_at, input logic [4:0] a, input logic [31:0] d);
    win_len = 0;
    for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
    do begin
      @(negedge clk_clk);
      win_len++;
      for (int i = 0; i < CH; i++) hi_cnt[i] += pwm_out[i] ? 1 : 0;
      if (win_len == wr_at) begin
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
      end else begin
        avs_write = 1'b0;
      end
    end while (period_tick !== 1'b1 && win_len < 1000);
    avs_write = 1'b0;
    checks++;
    if (period_tick !== 1'b1) begin
      errors++;
      $display("FAIL measure_timeout: window=%0d cycles, expected a tick", win_len);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [4:0]  addrs [9];
    addrs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd31};
    reset_reset = 1'b1;
    repeat (3) @(negedge clk_clk);
    checks++;
    if ({pwm_out, dir_out, period_tick} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: pwm=%b dir=%b tick=%b, expected all 0", pwm_out, dir_out, period_tick);
    end
    checks++;
    if (avs_readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_readdata: got %h expected 0", avs_readdata);
    end
    reset_reset = 1'b0;
    @(negedge clk_clk);
    foreach (addrs[k]) begin
      bus_read(addrs[k], rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_read_%0d: got %h expected 0", addrs[k], rd);
      end
    end
  endtask

  task automatic test_basic();
    bus_write(5'd1, 32'h1);
    bus_write(5'd4, 32'd25);
    bus_write(5'd0, 32'd100);
    wait_tick();
    for (int r = 0; r < 2; r++) begin
      measure(-1, 5'd0, 32'h0);
      checks++;
      if (hi_cnt[0] != 25) begin
        errors++;
        $display("FAIL basic_duty0: got %0d high cycles expected 25", hi_cnt[0]);
      end
      checks++;
      if (win_len != 100) begin
        errors++;
        $display("FAIL basic_tick_spacing: got %0d expected 100", win_len);
      end
      checks++;
      if (hi_cnt[1] != 0) begin
        errors++;
        $display("FAIL basic_disabled_ch1: got %0d expected 0", hi_cnt[1]);
      end
    end
  endtask

  task automatic test_full_and_zero();
    logic [31:0] rd;
    bus_write(5'd1, 32'h3);
    bus_write(5'd5, 32'd150);
    wait_tick();
    measure(-1, 5'd0, 32'h0);
    checks++;
    if (hi_cnt[1] != 100 || hi_cnt[0] != 25) begin
      errors++;
      $display("FAIL full_duty: ch1=%0d ch0=%0d expected 100 and 25", hi_cnt[1], hi_cnt[0]);
    end
    bus_read(5'd5, rd);
    checks++;
    if (rd !== 32'd150) begin
      errors++;
      $display("FAIL duty1_readback: got %h expected %h", rd, 32'd150);
    end
    bus_write(5'd5, 32'd0);
    wait_tick();
    measure(-1, 5'd0, 32'h0);
    checks++;
    if (hi_cnt[1] != 0) begin
      errors++;
      $display("FAIL zero_duty: ch1=%0d expected 0", hi_cnt[1]);
    end
  endtask

  task automatic test_mid_update();
    int exp_seq [5];
    exp_seq = '{25, 75, 75, 75, 40};
    // period 1: write 75 mid-period; 2: new duty; 3: write lands on the wrap
    // edge; 4: wrap took the old shadow; 5: new value applies.
    measure(10, 5'd4, 32'd75);
    checks++;
    if (hi_cnt[0] != exp_seq[0]) begin errors++; $display("FAIL mid_update_current: got %0d expected %0d", hi_cnt[0], exp_seq[0]); end
    measure(-1, 5'd0, 32'h0);
    checks++;
    if (hi_cnt[0] != exp_seq[1]) begin errors++; $display("FAIL mid_update_next: got %0d expected %0d", hi_cnt[0], exp_seq[1]); end
    measure(99, 5'd4, 32'd40);
    checks++;
    if (hi_cnt[0] != exp_seq[2]) begin errors++; $display("FAIL wrap_write_current: got %0d expected %0d", hi_cnt[0], exp_seq[2]); end
    measure(-1, 5'd0, 32'h0);
    checks++;
    if (hi_cnt[0] != exp_seq[3]) begin errors++; $display("FAIL wrap_write_old: got %0d expected %0d", hi_cnt[0], exp_seq[3]); end
    measure(-1, 5'd0, 32'h0);
    checks++;
    if (hi_cnt[0] != exp_seq[4]) begin errors++; $display("FAIL wrap_write_new: got %0d expected %0d", hi_cnt[0], exp_seq[4]); end
  endtask

  task automatic test_dir_reversal();
    logic [31:0] rd;
    bus_write(5'd1, 32'h7);
    bus_write(5'd6, 32'd50);
    wait_tick();
    measure(-1, 5'd0, 32'h0);
    checks++;
    if (hi_cnt[2] != 50 || dir_out[2] !== 1'b0) begin
      errors++;
      $display("FAIL rev_before: ch2=%0d dir=%b expected 50 and 0", hi_cnt[2], dir_out[2]);
    end
    bus_write(5'd6, 32'h8000_0000 | 32'd50);
    wait_tick();
    bus_read(5'd2, rd);
    checks++;
    if (rd !== 32'h0000_0401) begin
      errors++;
      $display("FAIL rev_status_brake: got %h expected 00000401", rd);
    end
    checks++;
    if (dir_out[2] !== 1'b0) begin
      errors++;
      $display("FAIL rev_dir_held: got %b expected 0", dir_out[2]);
    end
    measure(-1, 5'd0, 32'h0);
    checks++;
    if (hi_cnt[2] != 0) begin
      errors++;
      $display("FAIL rev_brake_low: ch2=%0d expected 0", hi_cnt[2]);
    end
    checks++;
    if (dir_out[2] !== 1'b1) begin
      errors++;
      $display("FAIL rev_dir_toggle: got %b expected 1", dir_out[2]);
    end
    measure(-1, 5'd0, 32'h0);
    checks++;
    if (hi_cnt[2] != 50) begin
      errors++;
      $display("FAIL rev_resume: ch2=%0d expected 50", hi_cnt[2]);
    end
    bus_read(5'd2, rd);
    checks++;
    if (rd !== 32'h0000_0001) begin
      errors++;
      $display("FAIL rev_status_clear: got %h expected 00000001", rd);
    end
    model_dir[2] = 1'b1;
  endtask

  task automatic test_random();
    int p;
    logic [CH-1:0] en;
    logic [CH-1:0] nd;
    int duty [CH];
    int exp_hi;
    int k;
    logic [31:0] rd;
    logic [31:0] exp_q [$];
    for (int it = 0; it < 6; it++) begin
      p  = $urandom_range(20, 200);
      en = CH'($urandom_range(0, 15));
      for (int i = 0; i < CH; i++) begin
        duty[i] = $urandom_range(0, p + 20);
        nd[i]   = ($urandom_range(0, 3) == 0) ? ~model_dir[i] : model_dir[i];
      end
      wait_tick();
      bus_write(5'd1, 32'(en));
      for (int i = 0; i < CH; i++) bus_write(5'(4 + i), {nd[i], 31'(duty[i])});
      bus_write(5'd0, 32'(p));
      wait_tick();
      checks++;
      if (dir_out !== model_dir) begin
        errors++;
        $display("FAIL rand%0d_dir_before: got %b expected %b", it, dir_out, model_dir);
      end
      for (int w = 0; w < 2; w++) begin
        measure(-1, 5'd0, 32'h0);
        checks++;
        if (win_len != p) begin
          errors++;
          $display("FAIL rand%0d_len: got %0d expected %0d", it, win_len, p);
        end
        for (int i = 0; i < CH; i++) begin
          exp_hi = (duty[i] < p) ? duty[i] : p;
          if (!en[i] || (w == 0 && nd[i] != model_dir[i])) exp_hi = 0;
          checks++;
          if (hi_cnt[i] != exp_hi) begin
            errors++;
            $display("FAIL rand%0d_win%0d_ch%0d: got %0d expected %0d (P=%0d duty=%0d)", it, w, i, hi_cnt[i], exp_hi, p, duty[i]);
          end
        end
      end
      checks++;
      if (dir_out !== nd) begin
        errors++;
        $display("FAIL rand%0d_dir_after: got %b expected %b", it, dir_out, nd);
      end
      model_dir = nd;
      k = $urandom_range(0, CH - 1);
      exp_q.push_back(32'(p));
      exp_q.push_back({nd[k], 31'(duty[k])});
      bus_read(5'd0, rd);
      checks++;
      if (rd !== exp_q[0]) begin errors++; $display("FAIL rand%0d_period_rb: got %h expected %h", it, rd, exp_q[0]); end
      void'(exp_q.pop_front());
      bus_read(5'(4 + k), rd);
      checks++;
      if (rd !== exp_q[0]) begin errors++; $display("FAIL rand%0d_duty%0d_rb: got %h expected %h", it, k, rd, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_period_zero();
    logic [31:0] rd;
    int bad = 0;
    bus_write(5'd0, 32'd0);
    @(negedge clk_clk);
    for (int c = 0; c < 50; c++) begin
      if (pwm_out !== '0 || period_tick !== 1'b0) bad++;
      @(negedge clk_clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL period_zero_outputs: %0d cycles active, expected 0", bad);
    end
    bus_read(5'd2, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL period_zero_status: got %h expected 0", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_write(5'd1, 32'hF);
    for (int i = 0; i < CH; i++) bus_write(5'(4 + i), {model_dir[i], 31'd60});
    bus_write(5'd0, 32'd60);
    wait_tick();
    repeat (10) @(negedge clk_clk);
    reset_reset = 1'b1;
    @(negedge clk_clk);
    checks++;
    if ({pwm_out, dir_out, period_tick} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: pwm=%b dir=%b tick=%b, expected all 0", pwm_out, dir_out, period_tick);
    end
    reset_reset = 1'b0;
    @(negedge clk_clk);
    for (int a = 0; a < 8; a++) begin
      bus_read(5'(a), rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_mid_read_%0d: got %h expected 0", a, rd);
      end
    end
    model_dir = '0;
  endtask

  initial begin
    reset_reset   = 1'b1;
    avs_address   = '0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    avs_read      = 1'b0;
    test_reset();
    test_basic();
    test_full_and_zero();
    test_mid_update();
    test_dir_reversal();
    test_random();
    test_period_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
